// File: rtl/heart_rate_calc.sv
// Beat-to-beat heart rate from a peak flag; RUNNING_AVG_EN averages the last 4 intervals.
// Latency: bpm_valid 20 cycles after the accepting beat edge; beat 1 cycle after it.
// No backpressure: outputs are free-running strobes, edges arriving mid-division are dropped.
module heart_rate_calc #(
    parameter int TICK_DIV   = 40000,
    parameter int MIN_IBI_MS = 300,
    parameter int MAX_IBI_MS = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       peak,
    output logic [7:0] bpm,
    output logic       bpm_valid,
    output logic       beat,
    output logic       no_signal
);

`ifdef RUNNING_AVG_EN
    localparam int          HIST_N   = 4;
    localparam logic [17:0] DIVIDEND = 18'd240000;
`else
    localparam int          HIST_N   = 1;
    localparam logic [17:0] DIVIDEND = 18'd60000;
`endif
    localparam int          PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [11:0] MIN_I    = 12'(MIN_IBI_MS);
    localparam logic [11:0] MAX_I    = 12'(MAX_IBI_MS);
    localparam logic [2:0]  NV_FULL  = 3'(HIST_N);

    typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE, DONE} state_t;

    state_t        state;
    logic          peak_s1, peak_s2, peak_d;
    logic [PW-1:0] presc;
    logic [11:0]   ibi_ms;
    logic [12:0]   sum;
    logic [2:0]    nvalid;
    logic [12:0]   div_rem;
    logic [17:0]   div_quo;
    logic [4:0]    div_cnt;
`ifdef RUNNING_AVG_EN
    logic [11:0]   hist [4];
`endif

    logic rise;
    logic tick;
    logic rem_ge;

    assign rise   = peak_s2 & ~peak_d;
    assign tick   = (presc == PW'(TICK_DIV - 1));
    assign rem_ge = {div_rem, div_quo[17]} >= {1'b0, sum};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            peak_s1   <= 1'b0;
            peak_s2   <= 1'b0;
            peak_d    <= 1'b0;
            presc     <= '0;
            ibi_ms    <= '0;
            sum       <= '0;
            nvalid    <= '0;
            div_rem   <= '0;
            div_quo   <= '0;
            div_cnt   <= '0;
            bpm       <= '0;
            bpm_valid <= 1'b0;
            beat      <= 1'b0;
            no_signal <= 1'b1;
`ifdef RUNNING_AVG_EN
            for (int i = 0; i < 4; i++) hist[i] <= '0;
`endif
        end else begin
            peak_s1   <= peak;
            peak_s2   <= peak_s1;
            peak_d    <= peak_s2;
            beat      <= 1'b0;
            bpm_valid <= 1'b0;

            if (tick) begin
                presc <= '0;
                if (ibi_ms != 12'hFFF) ibi_ms <= ibi_ms + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (rise) begin
                        presc  <= '0;
                        ibi_ms <= '0;
                        state  <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (ibi_ms > MAX_I) begin
                        // Rhythm lost: forget the history but keep showing the last rate.
                        sum       <= '0;
                        nvalid    <= '0;
                        no_signal <= 1'b1;
                        state     <= IDLE;
`ifdef RUNNING_AVG_EN
                        for (int i = 0; i < 4; i++) hist[i] <= '0;
`endif
                    end else if (rise && ibi_ms >= MIN_I) begin
                        beat   <= 1'b1;
                        presc  <= '0;
                        ibi_ms <= '0;
`ifdef RUNNING_AVG_EN
                        hist[0] <= ibi_ms;
                        hist[1] <= hist[0];
                        hist[2] <= hist[1];
                        hist[3] <= hist[2];
                        sum     <= sum + {1'b0, ibi_ms} - {1'b0, hist[3]};
`else
                        sum     <= {1'b0, ibi_ms};
`endif
                        if (nvalid != NV_FULL) nvalid <= nvalid + 1'b1;
                        if (nvalid >= NV_FULL - 3'd1) begin
                            div_rem <= '0;
                            div_quo <= DIVIDEND;
                            div_cnt <= '0;
                            state   <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    // Remainder stays below the 13-bit divisor, so 13-bit subtraction is exact.
                    div_rem <= rem_ge ? ({div_rem[11:0], div_quo[17]} - sum)
                                      : {div_rem[11:0], div_quo[17]};
                    div_quo <= {div_quo[16:0], rem_ge};
                    div_cnt <= div_cnt + 1'b1;
                    if (div_cnt == 5'd17) state <= DONE;
                end
                DONE: begin
                    bpm       <= (|div_quo[17:8]) ? 8'hFF : div_quo[7:0];
                    bpm_valid <= 1'b1;
                    no_signal <= 1'b0;
                    state     <= MEASURE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
